// File: rtl/ana_monitor.sv
// ana_monitor: registers the state/carry outputs of the `analysis` block,
// counts carry rising edges, detects the symbol walk 001 -> 010 -> 100 and
// offers a snapshot of the carry count over a valid/ready handshake.
module ana_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             o1,
  input  logic             o2,
  input  logic             o3,
  input  logic             c,
  input  logic             report_ready,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             hit,
  output logic             report_valid,
  output logic [CNT_W-1:0] report_data,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  logic [2:0]       sym_q;
  logic             c_q;
  logic             c_qq;
  logic             rise;
  logic [CNT_W-1:0] count_next;
  state_t           state;
  state_t           state_next;
  logic             hit_next;
  logic             transfer;

  // Input register stage: sample the symbol and a two-deep carry history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q <= 3'b000;
      c_q   <= 1'b0;
      c_qq  <= 1'b0;
    end else begin
      sym_q <= {o3, o2, o1};
      c_q   <= c;
      c_qq  <= c_q;
    end
  end

  // Carry edge detect and the value the counter takes on this edge.
  always_comb begin
    rise       = c_q & ~c_qq;
    count_next = count;
    if (rise) begin
      count_next = count + CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Carry-edge counter with a registered wrap pulse on the all-ones -> 0 step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= rise & (count == CNT_ONES);
    end
  end

  // Pattern FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pattern FSM next state; a 001 from any state restarts the walk.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (sym_q == 3'b001) state_next = S1;
        else                 state_next = IDLE;
      end
      S1: begin
        if (sym_q == 3'b010)      state_next = S2;
        else if (sym_q == 3'b001) state_next = S1;
        else                      state_next = IDLE;
      end
      S2: begin
        if (sym_q == 3'b010)      state_next = S2;
        else if (sym_q == 3'b001) state_next = S1;
        else                      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pattern FSM output: completion is a 100 seen while in S2.
  always_comb begin
    hit_next = 1'b0;
    if ((state == S2) && (sym_q == 3'b100)) begin
      hit_next = 1'b1;
    end else begin
      hit_next = 1'b0;
    end
  end

  assign transfer = report_valid & report_ready;

  // Registered hit pulse and the single-entry report slot with sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit          <= 1'b0;
      report_valid <= 1'b0;
      report_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      hit <= hit_next;
      if (hit_next && (!report_valid || transfer)) begin
        report_valid <= 1'b1;
        report_data  <= count_next;
      end else if (hit_next) begin
        overrun <= 1'b1;
      end else if (transfer) begin
        report_valid <= 1'b0;
      end else begin
        report_valid <= report_valid;
      end
    end
  end

endmodule
